// File: rtl/cpu_pkg.sv
// Shared CPU definitions: request kinds, opcodes, instruction field positions
// and the encode helpers used by the encoder and the control decoder.
package cpu_pkg;

  typedef enum logic [2:0] {
    KIND_R     = 3'd0,
    KIND_ADDIU = 3'd1,
    KIND_SUBIU = 3'd2,
    KIND_SW    = 3'd3,
    KIND_LW    = 3'd4
  } req_kind_e;

  localparam logic [5:0] OPC_R     = 6'b000000;
  localparam logic [5:0] OPC_ADDIU = 6'b001100;
  localparam logic [5:0] OPC_SUBIU = 6'b001101;
  localparam logic [5:0] OPC_SW    = 6'b010000;
  localparam logic [5:0] OPC_LW    = 6'b010001;

  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } wr_state_e;

  typedef struct packed {
    logic [2:0]  kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
  } enc_req_t;

  function automatic logic kind_is_legal(input logic [2:0] kind);
    return kind <= 3'd4;
  endfunction

  function automatic logic [5:0] opcode_of(input logic [2:0] kind);
    logic [5:0] opc;
    case (kind)
      KIND_R:     opc = OPC_R;
      KIND_ADDIU: opc = OPC_ADDIU;
      KIND_SUBIU: opc = OPC_SUBIU;
      KIND_SW:    opc = OPC_SW;
      KIND_LW:    opc = OPC_LW;
      default:    opc = 6'b000000;
    endcase
    return opc;
  endfunction

  // Inverse mapping for the control decoder; unknown opcodes decode as R.
  function automatic logic [2:0] kind_of_opcode(input logic [5:0] opc);
    logic [2:0] kind;
    case (opc)
      OPC_ADDIU: kind = KIND_ADDIU;
      OPC_SUBIU: kind = KIND_SUBIU;
      OPC_SW:    kind = KIND_SW;
      OPC_LW:    kind = KIND_LW;
      default:   kind = KIND_R;
    endcase
    return kind;
  endfunction

  function automatic logic [31:0] encode_instr(input enc_req_t r);
    logic [31:0] word;
    word = '0;
    word[OPC_MSB:OPC_LSB] = opcode_of(r.kind);
    word[RS_MSB:RS_LSB]   = r.rs;
    word[RT_MSB:RT_LSB]   = r.rt;
    if (r.kind == KIND_R) begin
      word[RD_MSB:RD_LSB]       = r.rd;
      word[SHAMT_MSB:SHAMT_LSB] = r.shamt;
      word[FUNCT_MSB:FUNCT_LSB] = r.funct;
    end else begin
      word[IMM_MSB:IMM_LSB] = r.imm;
    end
    return word;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head word and an occupancy count.
// Push is refused when full and pop when empty; clear flushes on the edge.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW + 1)'(1);
        2'b01:   count_d = count_q - (AW + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes instruction requests into 32-bit words, buffers them and writes
// them to instruction memory at consecutive word addresses from BASE_ADDR.
module instr_encoder
  import cpu_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_kind,
  input  logic [4:0]  req_rs,
  input  logic [4:0]  req_rt,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_shamt,
  input  logic [5:0]  req_funct,
  input  logic [15:0] req_imm,
  output logic        im_wr_en,
  output logic [31:0] im_addr,
  output logic [31:0] im_wr_data,
  input  logic        im_busy,
  output logic        err,
  output logic [15:0] wr_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  wr_state_e   state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        err_q, err_d;
  logic [15:0] wr_count_q, wr_count_d;

  enc_req_t    req;
  logic [31:0] enc_word;
  logic        kind_ok, accept, push, commit, last_word;
  logic        fifo_full, fifo_empty;
  logic [31:0] fifo_head;
  logic [CW-1:0] fifo_count;

  assign req = '{kind: req_kind, rs: req_rs, rt: req_rt, rd: req_rd,
                 shamt: req_shamt, funct: req_funct, imm: req_imm};
  assign enc_word = encode_instr(req);
  assign kind_ok  = kind_is_legal(req_kind);

  // No bypass: a pop in the same cycle never frees a slot for a full FIFO.
  assign req_ready = !fifo_full && !clear;
  assign accept    = req_valid && req_ready;
  assign push      = accept && kind_ok;
  assign commit    = (state_q == ST_WRITE) && !im_busy && !clear;
  assign last_word = (fifo_count == CW'(1)) && !push;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .push      (push),
    .push_data (enc_word),
    .pop       (commit),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:  if (!fifo_empty)          state_d = ST_WRITE;
        ST_WRITE: if (commit && last_word)  state_d = ST_IDLE;
        default:                            state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    im_wr_en   = 1'b0;
    im_wr_data = '0;
    if (state_q == ST_WRITE) begin
      im_wr_en   = 1'b1;
      im_wr_data = fifo_head;
    end
  end

  always_comb begin
    addr_d     = addr_q;
    err_d      = err_q;
    wr_count_d = wr_count_q;
    if (clear) begin
      addr_d     = BASE_ADDR;
      err_d      = 1'b0;
      wr_count_d = '0;
    end else begin
      if (commit) begin
        addr_d     = addr_q + 32'd4;
        wr_count_d = wr_count_q + 16'd1;
      end
      if (accept && !kind_ok) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= BASE_ADDR;
      err_q      <= 1'b0;
      wr_count_q <= '0;
    end else begin
      addr_q     <= addr_d;
      err_q      <= err_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign im_addr  = addr_q;
  assign err      = err_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-encoded words, handshake, stall,
// illegal kind, clear and reset scenarios.
module tb_instr_encoder;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_kind;
  logic [4:0]  req_rs, req_rt, req_rd, req_shamt;
  logic [5:0]  req_funct;
  logic [15:0] req_imm;
  logic        im_wr_en;
  logic [31:0] im_addr;
  logic [31:0] im_wr_data;
  logic        im_busy;
  logic        err;
  logic [15:0] wr_count;

  int compared = 0;
  int failed   = 0;

  logic [31:0] c_addr[$];
  logic [31:0] c_data[$];

  instr_encoder #(
    .DEPTH     (4),
    .BASE_ADDR (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_kind   (req_kind),
    .req_rs     (req_rs),
    .req_rt     (req_rt),
    .req_rd     (req_rd),
    .req_shamt  (req_shamt),
    .req_funct  (req_funct),
    .req_imm    (req_imm),
    .im_wr_en   (im_wr_en),
    .im_addr    (im_addr),
    .im_wr_data (im_wr_data),
    .im_busy    (im_busy),
    .err        (err),
    .wr_count   (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record each cycle that will commit at the coming rising edge.
  always @(negedge clk) begin
    if (im_wr_en && !im_busy && !clear && !rst) begin
      c_addr.push_back(im_addr);
      c_data.push_back(im_wr_data);
      $display("[%0t] commit addr=%08h data=%08h", $time, im_addr, im_wr_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_commit(input string tag, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] ga, gd;
    ga = 'x;
    gd = 'x;
    if (c_addr.size() > 0) begin
      ga = c_addr.pop_front();
      gd = c_data.pop_front();
    end
    chk32({tag, "_addr"}, ga, a);
    chk32({tag, "_data"}, gd, d);
  endtask

  task automatic drive_req(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                           input logic [15:0] imm);
    req_valid = 1'b1;
    req_kind  = k;
    req_rs    = rs;
    req_rt    = rt;
    req_rd    = rd;
    req_shamt = sh;
    req_funct = fn;
    req_imm   = imm;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; im_busy = 1'b0;
    req_valid = 1'b0; req_kind = '0; req_rs = '0; req_rt = '0; req_rd = '0;
    req_shamt = '0; req_funct = '0; req_imm = '0;

    // Reset state
    tick(); tick();
    chk1("rst_wr_en", im_wr_en, 1'b0);
    chk32("rst_addr", im_addr, 32'h0);
    chk32("rst_data", im_wr_data, 32'h0);
    chk1("rst_err", err, 1'b0);
    chk16("rst_count", wr_count, 16'd0);
    rst = 1'b0;
    tick();
    chk1("ready_after_rst", req_ready, 1'b1);

    // Single R-format write
    drive_req(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'hFFFF);
    chk1("r_ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    chk1("r_lat0_wr_en", im_wr_en, 1'b0);
    tick();
    chk1("r_wr_en", im_wr_en, 1'b1);
    chk32("r_addr", im_addr, 32'h0);
    chk32("r_data", im_wr_data, 32'h0022_1820);
    tick();
    chk1("r_done_wr_en", im_wr_en, 1'b0);
    chk16("r_count", wr_count, 16'd1);
    expect_commit("r_commit", 32'h0, 32'h0022_1820);

    // Back-to-back add-imm then load from a cleared pointer
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk32("clr_addr", im_addr, 32'h0);
    chk16("clr_count", wr_count, 16'd0);
    drive_req(3'd1, 5'd0, 5'd5, 5'd31, 5'd31, 6'h3F, 16'h0010);
    tick();
    drive_req(3'd4, 5'd4, 5'd6, 5'd0, 5'd0, 6'h0, 16'h0008);
    tick();
    req_valid = 1'b0;
    chk1("b2b_wr_en0", im_wr_en, 1'b1);
    chk32("b2b_data0", im_wr_data, 32'h3005_0010);
    tick();
    chk1("b2b_wr_en1", im_wr_en, 1'b1);
    chk32("b2b_addr1", im_addr, 32'h4);
    chk32("b2b_data1", im_wr_data, 32'h4486_0008);
    tick();
    chk1("b2b_idle", im_wr_en, 1'b0);
    chk16("b2b_count", wr_count, 16'd2);
    expect_commit("b2b_c0", 32'h0, 32'h3005_0010);
    expect_commit("b2b_c1", 32'h4, 32'h4486_0008);

    // Stall: five requests against a busy memory with DEPTH=4
    im_busy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive_req(3'd1, 5'd0, 5'(i), 5'd0, 5'd0, 6'd0, 16'(i));
      tick();
    end
    drive_req(3'd1, 5'd0, 5'd5, 5'd0, 5'd0, 6'd0, 16'd5);
    chk1("full_ready", req_ready, 1'b0);
    chk1("full_wr_en", im_wr_en, 1'b1);
    chk32("full_addr", im_addr, 32'h8);
    chk32("full_data", im_wr_data, 32'h3001_0001);
    tick(); tick();
    chk1("stall_ready", req_ready, 1'b0);
    chk32("stall_addr", im_addr, 32'h8);
    chk32("stall_data", im_wr_data, 32'h3001_0001);
    chk16("stall_count", wr_count, 16'd2);
    im_busy = 1'b0;
    #1;
    chk1("no_bypass_ready", req_ready, 1'b0);
    tick();
    chk32("rel_addr", im_addr, 32'hC);
    chk32("rel_data", im_wr_data, 32'h3002_0002);
    chk1("rel_ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    for (int n = 0; n < 20 && c_data.size() < 5; n++) tick();
    chk32("drain_commits", 32'(c_data.size()), 32'd5);
    for (int i = 1; i <= 5; i++) begin
      expect_commit("drain", 32'(4 + 4 * i), 32'h3000_0000 | (32'(i) << 16) | 32'(i));
    end
    tick();
    chk1("drain_idle", im_wr_en, 1'b0);
    chk16("drain_count", wr_count, 16'd7);
    chk32("drain_ptr", im_addr, 32'd28);

    // Illegal kind then a store
    drive_req(3'd7, 5'd9, 5'd9, 5'd9, 5'd9, 6'd9, 16'h9999);
    tick();
    req_valid = 1'b0;
    chk1("ill_err", err, 1'b1);
    tick(); tick();
    chk1("ill_no_write", im_wr_en, 1'b0);
    chk16("ill_count", wr_count, 16'd7);
    chk32("ill_no_commit", 32'(c_data.size()), 32'd0);
    drive_req(3'd3, 5'd4, 5'd6, 5'd0, 5'd0, 6'd0, 16'h0008);
    tick();
    req_valid = 1'b0;
    tick();
    chk32("sw_addr", im_addr, 32'd28);
    chk32("sw_data", im_wr_data, 32'h4086_0008);
    tick();
    expect_commit("sw_commit", 32'd28, 32'h4086_0008);
    chk1("err_sticky", err, 1'b1);
    chk16("sw_count", wr_count, 16'd8);

    // Clear with two words queued and a request pending
    im_busy = 1'b1;
    drive_req(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0);
    tick(); tick();
    clear = 1'b1;
    im_busy = 1'b0;
    #1;
    chk1("clr_ready", req_ready, 1'b0);
    tick();
    clear = 1'b0;
    req_valid = 1'b0;
    chk1("clr_wr_en", im_wr_en, 1'b0);
    chk1("clr_err", err, 1'b0);
    chk16("clr_count2", wr_count, 16'd0);
    chk32("clr_ptr", im_addr, 32'h0);
    tick();
    chk1("clr_empty", im_wr_en, 1'b0);
    chk32("clr_no_commit", 32'(c_data.size()), 32'd0);
    drive_req(3'd1, 5'd0, 5'd7, 5'd0, 5'd0, 6'd0, 16'h1234);
    tick();
    req_valid = 1'b0;
    tick(); tick();
    expect_commit("post_clr", 32'h0, 32'h3007_1234);
    chk32("post_clr_n", 32'(c_data.size()), 32'd0);

    // Reset asserted during a write
    im_busy = 1'b1;
    drive_req(3'd2, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h00AA);
    tick(); tick();
    req_valid = 1'b0;
    chk1("pre_rst_wr_en", im_wr_en, 1'b1);
    rst = 1'b1;
    #1;
    chk1("rst_async_wr_en", im_wr_en, 1'b0);
    chk32("rst_async_addr", im_addr, 32'h0);
    tick();
    rst = 1'b0;
    im_busy = 1'b0;
    tick(); tick(); tick();
    chk1("rst_fifo_empty", im_wr_en, 1'b0);
    chk16("rst_mid_count", wr_count, 16'd0);
    chk32("rst_no_commit", 32'(c_data.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
